// File: rtl/heavy_part_table_read_param.sv
`default_nettype none
// ============================================================================
// Module   : heavy_part_table_read_param
// Purpose  : Read-issue stage for one heavy-part bucket array. Incoming
//            {key, value, counter} records are buffered in a show-ahead FIFO.
//            One record is popped per cycle while downstream has room. Each
//            pop issues a synchronous bucket-RAM read at the hashed address
//            and forwards {timestamp, key, value}. The forwarded record is
//            delayed by RAM_LAT cycles so it lines up with the RAM read data.
// Ports    : clk          - clock
//            reset        - asynchronous active-low reset
//            in_wr        - write strobe for in_data
//            in_data      - {key, value, counter}, key in the MSBs
//            in_alf       - FIFO almost full (count >= ALF_THRESH, registered)
//            in_overflow  - sticky, a write was dropped while the FIFO was full
//            ram_rden     - bucket RAM read enable
//            ram_rdaddr   - bucket RAM read address (held between reads)
//            out_wr       - output record valid, aligned with RAM q
//            out_data     - {timestamp, key, value}, held while out_wr=0
//            out_alf      - downstream almost full, blocks new pops
// Options  : HEAVY_HASH_XOR_FOLD_EN - when defined, the read address is the
//            XOR of all ADDR_W-bit chunks of the MSB-zero-padded key instead
//            of the key[HASH_LSB +: ADDR_W] slice.
// Revision : 1.0 - initial release
// ============================================================================
module heavy_part_table_read_param #(
  parameter int KEY_W      = 32,
  parameter int VAL_W      = 32,
  parameter int CNT_W      = 32,
  parameter int TS_W       = 64,
  parameter int ADDR_W     = 12,
  parameter int HASH_LSB   = 12,
  parameter int FIFO_AW    = 9,
  parameter int ALF_THRESH = 256,
  parameter int RAM_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_wr,
  input  logic [KEY_W+VAL_W+CNT_W-1:0]  in_data,
  output logic                          in_alf,
  output logic                          in_overflow,
  output logic                          ram_rden,
  output logic [ADDR_W-1:0]             ram_rdaddr,
  output logic                          out_wr,
  output logic [TS_W+KEY_W+VAL_W-1:0]   out_data,
  input  logic                          out_alf
);

  localparam int C_REC_W = KEY_W + VAL_W;
  localparam int C_OUT_W = TS_W + KEY_W + VAL_W;
  localparam int C_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_FULL_CNT = (FIFO_AW+1)'(C_DEPTH);
  localparam logic [FIFO_AW:0] C_ALF_CNT  = (FIFO_AW+1)'(ALF_THRESH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The counter field is not forwarded, so only {key, value} is stored.
  logic [C_REC_W-1:0]  fifo_mem [C_DEPTH];

  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                in_alf_q, in_alf_d;
  logic                in_overflow_q, in_overflow_d;
  state_t              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
  // Stage 0 is the record captured at the pop (its valid is ram_rden);
  // stage RAM_LAT is the record presented on out_wr/out_data.
  logic [RAM_LAT:0]    vld_q, vld_d;
  logic [C_OUT_W-1:0]  dat_q [RAM_LAT+1];
  logic [C_OUT_W-1:0]  dat_d [RAM_LAT+1];

  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_wr;
  logic                pop_ok;
  logic                pop;
  logic [C_REC_W-1:0]  head_rec;
  logic [KEY_W-1:0]    head_key;
  logic [ADDR_W-1:0]   hash_addr;
  logic                unused_cnt_bits;

  assign unused_cnt_bits = ^in_data[CNT_W-1:0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == C_FULL_CNT);
  // Full is judged before any same-cycle pop, so a write at full is dropped.
  assign fifo_wr    = in_wr && !fifo_full;
  assign pop_ok     = !fifo_empty && !out_alf;
  // Pops only happen in RUN; IDLE spends one cycle recognising work is ready.
  assign pop        = (state_q == RUN) && pop_ok;

  // Show-ahead read: the head record is visible without a read request.
  assign head_rec = fifo_mem[rd_ptr_q];
  assign head_key = head_rec[C_REC_W-1 -: KEY_W];

`ifdef HEAVY_HASH_XOR_FOLD_EN
  localparam int C_NCHUNK = (KEY_W + ADDR_W - 1) / ADDR_W;
  logic [C_NCHUNK*ADDR_W-1:0] key_pad;

  assign key_pad = (C_NCHUNK*ADDR_W)'(head_key);

  always_comb begin
    hash_addr = '0;
    for (int i = 0; i < C_NCHUNK; i++) begin
      hash_addr = hash_addr ^ key_pad[i*ADDR_W +: ADDR_W];
    end
  end
`else
  assign hash_addr = head_key[HASH_LSB +: ADDR_W];
`endif

  always_comb begin
    ts_d          = ts_q + 1'b1;
    wr_ptr_d      = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q + (FIFO_AW+1)'(fifo_wr) - (FIFO_AW+1)'(pop);
    in_alf_d      = (count_q >= C_ALF_CNT);
    in_overflow_d = in_overflow_q | (in_wr & fifo_full);

    state_d = state_q;
    case (state_q)
      IDLE:    if (pop_ok)  state_d = RUN;
      RUN:     if (!pop_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdaddr_d = pop ? hash_addr : rdaddr_q;
    vld_d    = {vld_q[RAM_LAT-1:0], pop};
    dat_d[0] = pop ? {ts_q, head_rec} : dat_q[0];
    // Each stage only advances on a valid record so out_data holds when idle.
    for (int i = 1; i <= RAM_LAT; i++) begin
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_alf_q      <= 1'b0;
      in_overflow_q <= 1'b0;
      state_q       <= IDLE;
      ts_q          <= '0;
      rdaddr_q      <= '0;
      vld_q         <= '0;
      for (int i = 0; i <= RAM_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_alf_q      <= in_alf_d;
      in_overflow_q <= in_overflow_d;
      state_q       <= state_d;
      ts_q          <= ts_d;
      rdaddr_q      <= rdaddr_d;
      vld_q         <= vld_d;
      for (int i = 0; i <= RAM_LAT; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  // Storage array needs no reset: the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= in_data[CNT_W +: C_REC_W];
    end
  end

  assign in_alf      = in_alf_q;
  assign in_overflow = in_overflow_q;
  assign ram_rden    = vld_q[0];
  assign ram_rdaddr  = rdaddr_q;
  assign out_wr      = vld_q[RAM_LAT];
  assign out_data    = dat_q[RAM_LAT];

endmodule
`default_nettype wire

// File: tb/tb_heavy_part_table_read_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_heavy_part_table_read_param
// Purpose  : Scoreboard bench for heavy_part_table_read_param (RAM_LAT=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_heavy_part_table_read_param;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_wr = 1'b0;
  logic [95:0]  in_data = '0;
  logic         out_alf = 1'b0;
  logic         in_alf;
  logic         in_overflow;
  logic         ram_rden;
  logic [11:0]  ram_rdaddr;
  logic         out_wr;
  logic [127:0] out_data;

  always #5 clk = ~clk;

  heavy_part_table_read_param #(
    .RAM_LAT (LAT)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_wr       (in_wr),
    .in_data     (in_data),
    .in_alf      (in_alf),
    .in_overflow (in_overflow),
    .ram_rden    (ram_rden),
    .ram_rdaddr  (ram_rdaddr),
    .out_wr      (out_wr),
    .out_data    (out_data),
    .out_alf     (out_alf)
  );

  typedef struct packed {
    logic [31:0] key;
    logic [31:0] val;
  } rec_t;

  typedef struct packed {
    logic [31:0]  due;
    logic [127:0] data;
  } pend_t;

  rec_t  exp_q [$];
  pend_t pend_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rden_cnt = 0;
  int out_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Posedges seen since reset released; equals the DUT timestamp value.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: pops expectations on each read issue and each output record.
  always @(negedge clk) begin
    rec_t  r;
    pend_t p;
    if (reset) begin
      if (ram_rden) begin
        rden_cnt++;
        if (exp_q.size() == 0) begin
          chk("rden_unexpected", 128'(ram_rden), 128'd0);
        end else begin
          r = exp_q.pop_front();
          chk("ram_rdaddr", 128'(ram_rdaddr), 128'(r.key[23:12]));
          p.due  = 32'(cyc + LAT);
          p.data = {64'(cyc - 1), r.key, r.val};
          pend_q.push_back(p);
        end
      end
      if (out_wr) begin
        out_cnt++;
        if (pend_q.size() == 0) begin
          chk("out_wr_unexpected", 128'(out_wr), 128'd0);
        end else begin
          p = pend_q.pop_front();
          chk("out_wr_latency", 128'(cyc), 128'(p.due));
          chk("out_data", out_data, p.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_rec(input logic [31:0] key, input logic [31:0] val, input bit accept);
    in_wr   = 1'b1;
    in_data = {key, val, 32'($urandom)};
    if (accept) exp_q.push_back({key, val});
    tick(1);
    in_wr   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && i < budget) begin
      tick(1);
      i++;
    end
    chk("drain_timeout", 128'(exp_q.size() + pend_q.size()), 128'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_alf"},      128'(in_alf),      128'd0);
    chk({tag, "_in_overflow"}, 128'(in_overflow), 128'd0);
    chk({tag, "_ram_rden"},    128'(ram_rden),    128'd0);
    chk({tag, "_ram_rdaddr"},  128'(ram_rdaddr),  128'd0);
    chk({tag, "_out_wr"},      128'(out_wr),      128'd0);
    chk({tag, "_out_data"},    out_data,          128'd0);
  endtask

  function automatic logic [31:0] key_of(input int i);
    return 32'(i) * 32'h0000_1001 + 32'h0100_0000;
  endfunction

  initial begin
    int r0;
    int o0;
    int n;

    // Reset state
    #17;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    tick(1);

    // Single record, slice hash 0xABC
    write_rec(32'h00AB_C000, 32'hDEAD_BEEF, 1'b1);
    wait_drain(50);
    chk("single_out_cnt", 128'(out_cnt), 128'd1);

    // 300-record burst held off by out_alf, then released
    out_alf = 1'b1;
    r0 = rden_cnt;
    for (int i = 0; i < 255; i++) write_rec(key_of(i), 32'(i) ^ 32'hA5A5_0000, 1'b1);
    tick(2);
    chk("in_alf_at_255", 128'(in_alf), 128'd0);
    write_rec(key_of(255), 32'd255 ^ 32'hA5A5_0000, 1'b1);
    chk("in_alf_lag", 128'(in_alf), 128'd0);
    tick(1);
    chk("in_alf_at_256", 128'(in_alf), 128'd1);
    for (int i = 256; i < 300; i++) write_rec(key_of(i), 32'(i) ^ 32'hA5A5_0000, 1'b1);
    tick(5);
    chk("no_pop_while_alf", 128'(rden_cnt - r0), 128'd0);
    out_alf = 1'b0;
    n = 0;
    while (!ram_rden && n < 10) begin tick(1); n++; end
    n = 0;
    while (ram_rden && n < 400) begin tick(1); n++; end
    chk("burst_back_to_back", 128'(n), 128'd300);
    wait_drain(100);

    // Overflow: 513 writes into a 512-deep FIFO
    out_alf = 1'b1;
    for (int i = 0; i < 512; i++) write_rec(key_of(i) ^ 32'h0055_5000, 32'(i), 1'b1);
    chk("overflow_before", 128'(in_overflow), 128'd0);
    write_rec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("overflow_set", 128'(in_overflow), 128'd1);
    o0 = out_cnt;
    out_alf = 1'b0;
    wait_drain(700);
    chk("overflow_out_cnt", 128'(out_cnt - o0), 128'd512);
    chk("overflow_sticky", 128'(in_overflow), 128'd1);

    // 10-record stream with out_alf toggling every 4 cycles
    o0 = out_cnt;
    fork
      begin
        repeat (12) begin
          out_alf = ~out_alf;
          tick(4);
        end
        out_alf = 1'b0;
      end
      begin
        for (int i = 0; i < 10; i++) begin
          write_rec(32'h1234_0000 + 32'(i << 12), 32'h7700_0000 + 32'(i), 1'b1);
          tick(1);
        end
      end
    join
    out_alf = 1'b0;
    wait_drain(100);
    chk("toggle_out_cnt", 128'(out_cnt - o0), 128'd10);

    // Reset mid-burst: 50 queued, 2 reads in flight
    out_alf = 1'b1;
    for (int i = 0; i < 50; i++) write_rec(key_of(i) + 32'h0000_0777, 32'(i) + 32'h100, 1'b1);
    tick(2);
    out_alf = 1'b0;
    tick(3);
    #1;
    reset = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    pend_q.delete();
    o0 = out_cnt;
    r0 = rden_cnt;
    tick(3);
    @(negedge clk);
    reset = 1'b1;
    tick(20);
    chk("post_reset_no_out", 128'(out_cnt - o0), 128'd0);
    chk("post_reset_no_rden", 128'(rden_cnt - r0), 128'd0);
    write_rec(32'h0FED_C123, 32'h0BAD_F00D, 1'b1);
    wait_drain(50);
    chk("post_reset_out_cnt", 128'(out_cnt - o0), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
